// File: rtl/wb_arbiter_if.sv
// Writeback bus between the ALU / load unit and the register-file port.
// The arbiter sits on the slave side.
interface wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            we;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] wdata;
  logic [31:0]     pending_mask;
  logic [CW-1:0]   ld_count;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, we, rd_reg, wdata, pending_mask, ld_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, we, rd_reg, wdata, pending_mask, ld_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results win, loads wait in a small FIFO
// and are forced through after STARVE_LIMIT consecutive ALU grants.
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       mem_rd_r   [DEPTH];
  logic [XLEN-1:0]  mem_data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [SW-1:0]    starve_cnt_r;
  logic             we_r;
  logic [4:0]       rd_reg_r;
  logic [XLEN-1:0]  wdata_r;

  logic             fifo_empty_s;
  logic             ld_ready_s;
  logic             starve_s;
  logic             alu_grant_s;
  logic             ld_grant_s;
  logic             push_s;
  logic [31:0]      pending_s;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'd1 << rd;
  endfunction

  // Grant and handshake decode, from registered state only (no pop bypass)
  always_comb begin
    fifo_empty_s = (count_r == CW'(0));
    ld_ready_s   = (count_r < CW'(DEPTH)) && !rst;
    starve_s     = (starve_cnt_r == SW'(STARVE_LIMIT)) && !fifo_empty_s;
    alu_grant_s  = bus.alu_valid && !starve_s && !rst;
    ld_grant_s   = !alu_grant_s && !fifo_empty_s && !rst;
    push_s       = bus.ld_valid && ld_ready_s;
  end

  // Destinations of buffered loads, x0 never reported
  always_comb begin
    pending_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_r[i]) begin
        pending_s = pending_s | rd_onehot(mem_rd_r[i]);
      end else begin
        pending_s = pending_s;
      end
    end
    pending_s[0] = 1'b0;
  end

  // Load FIFO, starvation counter and registered register-file port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd_r[i]   <= 5'd0;
        mem_data_r[i] <= '0;
      end
      valid_r      <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      starve_cnt_r <= '0;
      we_r         <= 1'b0;
      rd_reg_r     <= 5'd0;
      wdata_r      <= '0;
    end else begin
      if (push_s) begin
        mem_rd_r[wr_ptr_r]   <= bus.ld_rd;
        mem_data_r[wr_ptr_r] <= bus.ld_data;
        valid_r[wr_ptr_r]    <= 1'b1;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (ld_grant_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + AW'(1);
      end
      case ({push_s, ld_grant_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (ld_grant_s || fifo_empty_s) begin
        starve_cnt_r <= '0;
      end else if (alu_grant_s && (starve_cnt_r != SW'(STARVE_LIMIT))) begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end
      // x0 writes are consumed but suppressed; address/data hold their last value
      if (alu_grant_s) begin
        we_r <= (bus.alu_rd != 5'd0);
        if (bus.alu_rd != 5'd0) begin
          rd_reg_r <= bus.alu_rd;
          wdata_r  <= bus.alu_data;
        end
      end else if (ld_grant_s) begin
        we_r <= (mem_rd_r[rd_ptr_r] != 5'd0);
        if (mem_rd_r[rd_ptr_r] != 5'd0) begin
          rd_reg_r <= mem_rd_r[rd_ptr_r];
          wdata_r  <= mem_data_r[rd_ptr_r];
        end
      end else begin
        we_r <= 1'b0;
      end
    end
  end

  assign bus.alu_ready    = alu_grant_s;
  assign bus.ld_ready     = ld_ready_s;
  assign bus.we           = we_r;
  assign bus.rd_reg       = rd_reg_r;
  assign bus.wdata        = wdata_r;
  assign bus.pending_mask = pending_s;
  assign bus.ld_count     = count_r;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  wb_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: queue of buffered loads, starvation count, last write
  logic [4:0]  mq_rd[$];
  logic [31:0] mq_data[$];
  int          m_sc;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;

  task automatic model_clear();
    mq_rd.delete(); mq_data.delete();
    m_sc = 0; m_we = 1'b0; m_rd = 5'd0; m_wdata = 32'd0;
  endtask

  function automatic bit exp_alu_ready();
    return bus.alu_valid && !(m_sc == LIMIT && mq_rd.size() > 0);
  endfunction

  function automatic bit exp_ld_ready();
    return mq_rd.size() < DEPTH;
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] m = 32'd0;
    foreach (mq_rd[i]) m[mq_rd[i]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock: evaluate the arbitration rules on the current inputs, then advance
  task automatic tick();
    int n = mq_rd.size();
    bit ga = exp_alu_ready();
    bit gl = !ga && (n > 0);
    logic av = bus.alu_valid; logic [4:0] ard = bus.alu_rd; logic [31:0] ad = bus.alu_data;
    logic lv = bus.ld_valid;  logic [4:0] lrd = bus.ld_rd;  logic [31:0] ld = bus.ld_data;
    logic [4:0] hr; logic [31:0] hd;
    @(posedge clk);
    if (ga) begin
      m_we = (ard != 5'd0);
      if (ard != 5'd0) begin m_rd = ard; m_wdata = ad; end
    end else if (gl) begin
      hr = mq_rd.pop_front(); hd = mq_data.pop_front();
      m_we = (hr != 5'd0);
      if (hr != 5'd0) begin m_rd = hr; m_wdata = hd; end
    end else begin
      m_we = 1'b0;
    end
    if (lv && n < DEPTH) begin mq_rd.push_back(lrd); mq_data.push_back(ld); end
    if (gl || n == 0) m_sc = 0;
    else if (ga && m_sc < LIMIT) m_sc = m_sc + 1;
    if (av === 1'bx) m_we = 1'bx;
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = 5'd0; bus.ld_data  = 32'd0;
  endtask

  task automatic test_reset();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h1111_1111;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd4; bus.ld_data = 32'h2222_2222;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", bus.we); end
    n_cmp++; if (bus.rd_reg !== 5'd0) begin n_err++; $display("FAIL rst_rd_reg: got %0d want 0", bus.rd_reg); end
    n_cmp++; if (bus.wdata !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", bus.wdata); end
    n_cmp++; if (bus.ld_count !== 2'd0) begin n_err++; $display("FAIL rst_ld_count: got %0d want 0", bus.ld_count); end
    n_cmp++; if (bus.pending_mask !== 32'd0) begin n_err++; $display("FAIL rst_pending: got %h want 0", bus.pending_mask); end
    n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL rst_ld_ready: got %b want 0", bus.ld_ready); end
    n_cmp++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL rst_alu_ready: got %b want 0", bus.alu_ready); end
    rst = 1'b0;
    idle_inputs();
    model_clear();
    #1;
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ld_ready: got %b want 1", bus.ld_ready); end
    tick();
    n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL post_rst_we: got %b want 0", bus.we); end
    n_cmp++; if (bus.ld_count !== 2'd0) begin n_err++; $display("FAIL post_rst_count: got %0d want 0", bus.ld_count); end
  endtask

  task automatic test_alu_only();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready: got %b want 1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    n_cmp++; if (bus.we !== 1'b1) begin n_err++; $display("FAIL alu_we: got %b want 1", bus.we); end
    n_cmp++; if (bus.rd_reg !== 5'd5) begin n_err++; $display("FAIL alu_rd_reg: got %0d want 5", bus.rd_reg); end
    n_cmp++; if (bus.wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alu_wdata: got %h want deadbeef", bus.wdata); end
    tick();
    n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL idle_we: got %b want 0", bus.we); end
    n_cmp++; if (bus.wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL idle_hold_wdata: got %h want deadbeef", bus.wdata); end
  endtask

  task automatic test_load_idle();
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h0000_1234;
    #1;
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL ld_ready: got %b want 1", bus.ld_ready); end
    tick();
    bus.ld_valid = 1'b0;
    n_cmp++; if (bus.pending_mask !== 32'h0000_0080) begin n_err++; $display("FAIL ld_pending_t1: got %h want 80", bus.pending_mask); end
    n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL ld_we_t1: got %b want 0", bus.we); end
    tick();
    n_cmp++; if (bus.we !== 1'b1 || bus.rd_reg !== 5'd7 || bus.wdata !== 32'h0000_1234) begin
      n_err++; $display("FAIL ld_write_t2: got we=%b rd=%0d data=%h want we=1 rd=7 data=1234", bus.we, bus.rd_reg, bus.wdata); end
    n_cmp++; if (bus.pending_mask !== 32'd0) begin n_err++; $display("FAIL ld_pending_t2: got %h want 0", bus.pending_mask); end
  endtask

  task automatic test_fill();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0A0A_0A0A;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd10; bus.ld_data = 32'h1000_000A;
    tick();
    bus.ld_rd = 5'd11; bus.ld_data = 32'h1000_000B;
    tick();
    bus.ld_rd = 5'd12; bus.ld_data = 32'h1000_000C;
    #1;
    n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL fill_ld_ready: got %b want 0", bus.ld_ready); end
    tick();
    n_cmp++; if (bus.ld_count !== 2'd2) begin n_err++; $display("FAIL fill_count: got %0d want 2", bus.ld_count); end
    n_cmp++; if (bus.pending_mask !== 32'h0000_0C00) begin n_err++; $display("FAIL fill_pending: got %h want c00", bus.pending_mask); end
    idle_inputs();
    tick();
    n_cmp++; if (bus.we !== 1'b1 || bus.rd_reg !== 5'd10 || bus.wdata !== 32'h1000_000A) begin
      n_err++; $display("FAIL fill_drain_a: got rd=%0d data=%h want rd=10 data=1000000a", bus.rd_reg, bus.wdata); end
    tick();
    n_cmp++; if (bus.we !== 1'b1 || bus.rd_reg !== 5'd11 || bus.wdata !== 32'h1000_000B) begin
      n_err++; $display("FAIL fill_drain_b: got rd=%0d data=%h want rd=11 data=1000000b", bus.rd_reg, bus.wdata); end
  endtask

  task automatic test_starvation();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'hA000_0000;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'hCAFE_0009;
    tick();
    bus.ld_valid = 1'b0;
    for (int k = 1; k <= LIMIT; k++) begin
      bus.alu_data = 32'hA000_0000 + 32'(k);
      #1;
      n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_alu_ready_%0d: got %b want 1", k, bus.alu_ready); end
      tick();
      n_cmp++; if (bus.wdata !== 32'hA000_0000 + 32'(k)) begin n_err++; $display("FAIL starve_alu_wdata_%0d: got %h", k, bus.wdata); end
    end
    n_cmp++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL starve_block: got %b want 0", bus.alu_ready); end
    tick();
    n_cmp++; if (bus.we !== 1'b1 || bus.rd_reg !== 5'd9 || bus.wdata !== 32'hCAFE_0009) begin
      n_err++; $display("FAIL starve_load_write: got rd=%0d data=%h want rd=9 data=cafe0009", bus.rd_reg, bus.wdata); end
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_clear: got %b want 1", bus.alu_ready); end
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h5555_5555;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'h6666_6666;
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL rd0_alu_ready: got %b want 1", bus.alu_ready); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL rd0_alu_we: got %b want 0", bus.we); end
    n_cmp++; if (bus.ld_count !== 2'd1 || bus.pending_mask !== 32'd0) begin
      n_err++; $display("FAIL rd0_buffered: got count=%0d mask=%h want count=1 mask=0", bus.ld_count, bus.pending_mask); end
    tick();
    n_cmp++; if (bus.we !== 1'b0 || bus.ld_count !== 2'd0) begin
      n_err++; $display("FAIL rd0_ld_pop: got we=%b count=%0d want we=0 count=0", bus.we, bus.ld_count); end
    n_cmp++; if (bus.rd_reg !== 5'd9 || bus.wdata !== 32'hCAFE_0009) begin
      n_err++; $display("FAIL rd0_hold: got rd=%0d data=%h want rd=9 data=cafe0009", bus.rd_reg, bus.wdata); end
  endtask

  task automatic test_reset_midop();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h0202_0202;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd20; bus.ld_data = 32'h2000_0014;
    tick();
    bus.ld_rd = 5'd21; bus.ld_data = 32'h2000_0015;
    tick();
    bus.ld_valid = 1'b0;
    n_cmp++; if (bus.ld_count !== 2'd2) begin n_err++; $display("FAIL midop_prefill: got %0d want 2", bus.ld_count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.ld_count !== 2'd0 || bus.pending_mask !== 32'd0 || bus.we !== 1'b0) begin
      n_err++; $display("FAIL midop_async_clear: got count=%0d mask=%h we=%b want 0/0/0", bus.ld_count, bus.pending_mask, bus.we); end
    n_cmp++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL midop_alu_ready: got %b want 0", bus.alu_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    model_clear();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL midop_ghost_write_%0d: got we=%b rd=%0d", k, bus.we, bus.rd_reg); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.alu_valid = ($urandom_range(0, 9) < 6);
      bus.alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.alu_data  = $urandom;
      bus.ld_valid  = ($urandom_range(0, 1) == 1);
      bus.ld_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.ld_data   = $urandom;
      #1;
      n_cmp++; if (bus.alu_ready !== exp_alu_ready()) begin n_err++; $display("FAIL rnd_alu_ready c%0d: got %b want %b", c, bus.alu_ready, exp_alu_ready()); end
      n_cmp++; if (bus.ld_ready !== exp_ld_ready()) begin n_err++; $display("FAIL rnd_ld_ready c%0d: got %b want %b", c, bus.ld_ready, exp_ld_ready()); end
      tick();
      n_cmp++; if (bus.we !== m_we || bus.rd_reg !== m_rd || bus.wdata !== m_wdata) begin
        n_err++; $display("FAIL rnd_write c%0d: got we=%b rd=%0d data=%h want we=%b rd=%0d data=%h", c, bus.we, bus.rd_reg, bus.wdata, m_we, m_rd, m_wdata); end
      n_cmp++; if (bus.ld_count !== 2'(mq_rd.size()) || bus.pending_mask !== exp_pending()) begin
        n_err++; $display("FAIL rnd_buffer c%0d: got count=%0d mask=%h want count=%0d mask=%h", c, bus.ld_count, bus.pending_mask, mq_rd.size(), exp_pending()); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_clear();
    test_reset();
    test_alu_only();
    test_load_idle();
    test_fill();
    test_starvation();
    test_rd_zero();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- XLEN, 32, data width.
- DEPTH, 2, load-buffer entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive ALU grants allowed while the load buffer is non-empty.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- alu_valid, in, 1, ALU writeback request.
- alu_ready, out, 1, ALU request granted this cycle.
- alu_rd, in, 5, ALU destination register.
- alu_data, in, XLEN, ALU result.
- ld_valid, in, 1, load-unit writeback offer.
- ld_ready, out, 1, load buffer can accept.
- ld_rd, in, 5, load destination register.
- ld_data, in, XLEN, load data.
- we, out, 1, register-file write enable (registered).
- rd_reg, out, 5, register-file write address (registered).
- wdata, out, XLEN, register-file write data (registered).
- pending_mask, out, 32, bit i set while a buffered load targets xi.
- ld_count, out, $clog2(DEPTH)+1, buffered load count.

Function
REQ-003 A load SHALL transfer into the FIFO on a rising edge where ld_valid && ld_ready; ld_valid/ld_rd/ld_data are ignored otherwise.
REQ-004 ld_ready SHALL be (ld_count < DEPTH) && !rst, derived from registered count only, with no same-cycle pop bypass.
REQ-005 Each cycle exactly one source SHALL be granted: ALU if alu_valid && !starve; else FIFO head if ld_count > 0; else none.
REQ-006 starve SHALL be (starve_cnt == STARVE_LIMIT) && (ld_count > 0); alu_ready SHALL be alu_valid && !starve, combinational.
REQ-007 starve_cnt SHALL increment (saturating at STARVE_LIMIT) when ALU is granted while ld_count > 0, and clear when the FIFO head is granted or ld_count == 0.
REQ-008 The granted write SHALL appear on we/rd_reg/wdata one cycle after the grant; latency is 1 cycle for ALU and >=2 cycles from load acceptance.
REQ-009 A granted write with rd == 0 SHALL be consumed (FIFO popped / alu_ready high) but SHALL drive we=0; rd_reg and wdata SHALL then hold their previous values.
REQ-010 When no grant occurs, we SHALL be 0 on the next cycle and rd_reg/wdata SHALL hold.
REQ-011 A simultaneous push and pop SHALL leave ld_count unchanged; a pop when empty or a push when full SHALL be impossible by construction.
REQ-012 FIFO read/write pointers SHALL wrap modulo DEPTH; loads SHALL be written back in acceptance order.
REQ-013 pending_mask SHALL be the OR of one-hot decodes of ld_rd over all valid entries, bit 0 forced to 0, updated in the same cycle as ld_count.
REQ-014 The block SHALL NOT reorder writes within a source, nor resolve same-rd ordering between sources (owned by hazard logic via pending_mask).

Reset
REQ-015 While rst is high: we=0, rd_reg=0, wdata=0, ld_count=0, pending_mask=0, starve_cnt=0, pointers=0, ld_ready=0, alu_ready=0.
REQ-016 Reset asserted mid-operation SHALL discard all buffered loads immediately (asynchronously), with no write issued for them.
REQ-017 On the first edge after rst deasserts, the block SHALL behave as empty and idle.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle we=1, rd_reg=5, wdata=0xDEADBEEF; alu_ready=1.
- Load, ALU idle: ld (rd=7, 0x1234) accepted at cycle T -> pending_mask[7]=1 at T+1; we=1, rd_reg=7, wdata=0x1234 at T+2; pending_mask=0 at T+2.
- Fill: three back-to-back loads with ALU busy -> ld_ready=0 after two; the third is held; ld_count=2.
- Starvation: ALU valid every cycle with one buffered load -> after 4 ALU grants, alu_ready=0 for one cycle and the load is written; the counter then clears.
- rd=0: ALU rd=0 and load rd=0 -> both consumed, we stays 0, pending_mask[0] never set.
- Reset mid-op: rst pulsed with ld_count=2 -> ld_count=0, pending_mask=0, we=0; no buffered write ever appears.
